r4_ibutter_seq: RTL and testbench
=================================

# r4_ibutter_seq

Sequential inverse radix-4 butterfly: the companion to the forward radix-4 butterfly (4-bit complex inputs xr/xi, 4-bit outputs selected by c1..c3) that reconstructs time-domain samples from its frequency-domain outputs. It accepts four complex samples serially over a valid/ready handshake and computes the unscaled inverse 4-point DFT. It then emits the four results serially with their index. It sits behind the forward butterfly in the user project area, driven from logic-analyzer or Wishbone-side glue.

## Interface
Parameters:
- W, 4, signed input component width; outputs are W+2 bits (full precision, no scaling)

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  synchronous reset, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- xr_in  in  W  real part of input sample, two's complement
- xi_in  in  W  imaginary part of input sample, two's complement
- out_valid  out  1  output sample valid
- out_ready  in  1  consumer accepts output
- Xr_out  out  W+2  real part of result X_k
- Xi_out  out  W+2  imaginary part of result X_k
- out_idx  out  2  index k of current output (0..3)
- busy  out  1  high in any state other than LOAD with zero samples held

## Operation
- FSM states: LOAD, COMPUTE, EMIT.
- LOAD: in_ready=1. On each in_valid&in_ready, store the sample at slot in_cnt (0..3) and increment in_cnt. When the 4th sample (in_cnt==3) is accepted, go to COMPUTE.
- COMPUTE (one cycle): in_ready=0. Register all four results into the output buffer, then go to EMIT with out_cnt=0.
- EMIT: out_valid=1, out_idx=out_cnt, Xr_out/Xi_out = buffer[out_cnt]. On out_valid&out_ready, increment out_cnt. When out_cnt==3 is accepted, return to LOAD with in_cnt=0. in_ready=0 throughout EMIT.
- Arithmetic: sign-extend inputs to W+2 bits; all sums are exact, with no overflow possible.
  - X0r = x0r+x1r+x2r+x3r; X0i = x0i+x1i+x2i+x3i
  - X1r = x0r−x1i−x2r+x3i; X1i = x0i+x1r−x2i−x3r
  - X2r = x0r−x1r+x2r−x3r; X2i = x0i−x1i+x2i−x3i
  - X3r = x0r+x1i−x2r−x3i; X3i = x0i−x1r−x2i+x3r
- Xr_out/Xi_out/out_idx must hold stable while out_valid=1 and out_ready=0.
- Outside EMIT, Xr_out/Xi_out hold the last driven value. Verification checks them only when out_valid=1.

## Timing
- Reset values: state=LOAD, in_cnt=0, out_cnt=0, in_ready=1, out_valid=0, out_idx=0, Xr_out=0, Xi_out=0, busy=0. Sample and result buffers are cleared to 0.
- RST has priority over all handshakes. Reset mid-LOAD discards partial samples. Reset mid-EMIT discards the remaining outputs. No output handshake completes in the reset cycle.
- Latency: 4th input accepted at edge N → COMPUTE during cycle N+1 → out_valid=1 from cycle N+2. X0..X3 then appear on consecutive cycles when out_ready is held high.
- Throughput: one block per 9 cycles with no stalls (4 load + 1 compute + 4 emit). There is no overlap of load and emit.
- in_ready and out_valid are registered (state-decoded), with no combinational path from in_valid or out_ready.
- in_valid gaps in LOAD simply pause in_cnt. Back-to-back samples are accepted every cycle.

## Structure
- Shared package r4_pkg: state enum (LOAD, COMPUTE, EMIT), localparam for points-per-block (4), and a complex sample struct {re, im}.
- Sub-module r4_ibutter_core: purely combinational inverse DFT-4 on four complex W-bit inputs, producing four W+2-bit outputs. It is reusable for a parallel variant.
- Top r4_ibutter_seq: FSM, counters, 4-entry sample buffer, 4-entry result buffer, and output mux.

## Test plan
- Impulse: inputs (1,0),(0,0),(0,0),(0,0) → outputs k=0..3 all (1,0), out_valid first seen 2 cycles after 4th accept.
- Shifted impulse: x1=(1,0), others 0 → X0=(1,0), X1=(0,1), X2=(−1,0), X3=(0,−1).
- Extremes: all four inputs (−8,−8) → X0=(−32,−32), X1=X2=X3=(0,0). Also all (7,7) → X0=(28,28), others 0. No wrap.
- Backpressure: out_ready low for 3 cycles during X1 → X1 and out_idx=1 stable; in_ready=0 throughout EMIT; then X2, X3 follow in order.
- Reset mid-operation: assert RST after 2 accepted samples, then feed a fresh 4-sample block → results depend only on the new block. Assert RST during EMIT at k=2 → out_valid=0 next cycle, in_ready=1.
- Round trip: random 4-sample blocks through a forward-DFT-4 model, then into this block → each output equals 4× the original sample. Run 1000 blocks with random in_valid/out_ready gaps.

Source files
------------

// File: rtl/r4_pkg.sv
// Shared types for the radix-4 inverse butterfly: FSM states, block size, complex sample.
package r4_pkg;

  localparam int unsigned NumPts  = 4;
  localparam int unsigned SampleW = 4;

  typedef enum logic [1:0] {
    StLoad,
    StCompute,
    StEmit
  } state_e;

  typedef struct packed {
    logic [SampleW-1:0] re;
    logic [SampleW-1:0] im;
  } cplx_t;

endpackage

// File: rtl/r4_ibutter_core.sv
// Combinational unscaled inverse 4-point DFT; outputs grow by two bits so no sum can wrap.
module r4_ibutter_core
  import r4_pkg::*;
#(
  parameter int unsigned W = SampleW
) (
  input  logic [NumPts-1:0][W-1:0]   xr,
  input  logic [NumPts-1:0][W-1:0]   xi,
  output logic [NumPts-1:0][W+1:0]   yr,
  output logic [NumPts-1:0][W+1:0]   yi
);

  localparam int unsigned OW = W + 2;

  logic signed [OW-1:0] ar [NumPts];
  logic signed [OW-1:0] ai [NumPts];

  always_comb begin
    for (int n = 0; n < NumPts; n++) begin
      ar[n] = {{2{xr[n][W-1]}}, xr[n]};
      ai[n] = {{2{xi[n][W-1]}}, xi[n]};
    end
  end

  // Twiddle factors are powers of +j, so every term is a plain add or subtract.
  always_comb begin
    yr[0] = ar[0] + ar[1] + ar[2] + ar[3];
    yi[0] = ai[0] + ai[1] + ai[2] + ai[3];
    yr[1] = ar[0] - ai[1] - ar[2] + ai[3];
    yi[1] = ai[0] + ar[1] - ai[2] - ar[3];
    yr[2] = ar[0] - ar[1] + ar[2] - ar[3];
    yi[2] = ai[0] - ai[1] + ai[2] - ai[3];
    yr[3] = ar[0] + ai[1] - ar[2] - ai[3];
    yi[3] = ai[0] - ar[1] - ai[2] + ar[3];
  end

endmodule

// File: rtl/r4_ibutter_seq.sv
// Sequential inverse radix-4 butterfly: loads four samples, computes in one cycle,
// then emits the four results with their index over a valid/ready handshake.
module r4_ibutter_seq
  import r4_pkg::*;
#(
  parameter int unsigned W = SampleW
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] xr_in,
  input  logic [W-1:0] xi_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W+1:0] Xr_out,
  output logic [W+1:0] Xi_out,
  output logic [1:0]   out_idx,
  output logic         busy
);

  localparam int unsigned OW = W + 2;

  if (W != SampleW) begin : g_w_check
    $error("r4_ibutter_seq: W must match r4_pkg::SampleW");
  end

  state_e                       state_q, state_d;
  logic [1:0]                   in_cnt_q, out_cnt_q;
  cplx_t [NumPts-1:0]           samp_q;
  logic  [NumPts-1:0][OW-1:0]   res_r_q, res_i_q;
  logic  [NumPts-1:0][W-1:0]    core_xr, core_xi;
  logic  [NumPts-1:0][OW-1:0]   core_yr, core_yi;
  logic  [OW-1:0]               xr_q, xi_q;
  logic                         in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    for (int n = 0; n < NumPts; n++) begin
      core_xr[n] = samp_q[n].re;
      core_xi[n] = samp_q[n].im;
    end
  end

  r4_ibutter_core #(
    .W (W)
  ) u_core (
    .xr (core_xr),
    .xi (core_xi),
    .yr (core_yr),
    .yi (core_yi)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= StLoad;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:    if (in_fire && in_cnt_q == 2'd3) state_d = StCompute;
      StCompute: state_d = StEmit;
      StEmit:    if (out_fire && out_cnt_q == 2'd3) state_d = StLoad;
      default:   state_d = StLoad;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StLoad);
    out_valid = (state_q == StEmit);
    busy      = !((state_q == StLoad) && (in_cnt_q == 2'd0));
  end

  assign out_idx = out_cnt_q;
  assign Xr_out  = xr_q;
  assign Xi_out  = xi_q;

  // Output registers are reloaded only on COMPUTE or an accepted output, so they hold
  // steadily under backpressure and keep X3 after the block ends.
  always_ff @(posedge CLK) begin
    if (RST) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      samp_q    <= '0;
      res_r_q   <= '0;
      res_i_q   <= '0;
      xr_q      <= '0;
      xi_q      <= '0;
    end else begin
      if (in_fire) begin
        samp_q[in_cnt_q].re <= xr_in;
        samp_q[in_cnt_q].im <= xi_in;
        in_cnt_q            <= in_cnt_q + 2'd1;
      end
      if (state_q == StCompute) begin
        res_r_q   <= core_yr;
        res_i_q   <= core_yi;
        xr_q      <= core_yr[0];
        xi_q      <= core_yi[0];
        out_cnt_q <= '0;
      end
      if (out_fire) begin
        out_cnt_q <= out_cnt_q + 2'd1;
        if (out_cnt_q != 2'd3) begin
          xr_q <= res_r_q[out_cnt_q + 2'd1];
          xi_q <= res_i_q[out_cnt_q + 2'd1];
        end
      end
    end
  end

endmodule

// File: tb/tb_r4_ibutter_seq.sv
// Self-checking bench for r4_ibutter_seq against a twiddle-table DFT-4 model.
module tb_r4_ibutter_seq;

  localparam int W = 4;

  typedef int arr4_t [4];

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] xr_in = '0;
  logic [W-1:0] xi_in = '0;
  logic         in_ready, out_valid, busy;
  logic [W+1:0] Xr_out, Xi_out;
  logic [1:0]   out_idx;

  int n_assert = 0;
  int n_fail   = 0;

  r4_ibutter_seq #(.W(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .xr_in     (xr_in),
    .xi_in     (xi_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Xr_out    (Xr_out),
    .Xi_out    (Xi_out),
    .out_idx   (out_idx),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input integer got, input integer want);
    n_assert++;
    assert (got === want)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  // X_k = sum_n x_n * w^(kn), w = +j (inverse) or -j (forward).
  function automatic void dft4(input arr4_t ar, input arr4_t ai, input bit inv,
                               output arr4_t br, output arr4_t bi);
    int m, wr, wi;
    for (int k = 0; k < 4; k++) begin
      br[k] = 0;
      bi[k] = 0;
      for (int n = 0; n < 4; n++) begin
        m = (k * n) % 4;
        if (!inv) m = (4 - m) % 4;
        case (m)
          0:       begin wr = 1;  wi = 0;  end
          1:       begin wr = 0;  wi = 1;  end
          2:       begin wr = -1; wi = 0;  end
          default: begin wr = 0;  wi = -1; end
        endcase
        br[k] += ar[n] * wr - ai[n] * wi;
        bi[k] += ar[n] * wi + ai[n] * wr;
      end
    end
  endfunction

  task automatic push(input int r, input int i, input int maxgap);
    int g, t;
    g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
    repeat (g) begin
      @(negedge CLK);
      in_valid = 1'b0;
    end
    @(negedge CLK);
    in_valid = 1'b1;
    xr_in    = W'(r);
    xi_in    = W'(i);
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 50) check("in_ready_timeout", in_ready, 1);
    @(posedge CLK);
  endtask

  task automatic pull(input arr4_t wr, input arr4_t wi, input int rdy_pct,
                      input int stall_k, input int stop_k);
    int k, cyc, stalls;
    k = 0; cyc = 0; stalls = 0;
    while (k < 4) begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) check("latency_out_valid", out_valid, 1);
      if (cyc > 300) begin
        check("pull_timeout", k, 4);
        return;
      end
      if (out_valid) begin
        check("out_idx", out_idx, k);
        check("Xr_out", $signed(Xr_out), wr[k]);
        check("Xi_out", $signed(Xi_out), wi[k]);
        check("in_ready_in_emit", in_ready, 0);
        if (k == stop_k) return;
        if (k == stall_k && stalls < 3) begin
          out_ready = 1'b0;
          stalls++;
        end else begin
          out_ready = ($urandom_range(0, 99) < rdy_pct);
        end
        if (out_ready) k++;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic load_block(input arr4_t r, input arr4_t i, input int maxgap);
    for (int n = 0; n < 4; n++) push(r[n], i[n], maxgap);
    @(negedge CLK);
    in_valid = 1'b0;
    check("compute_out_valid", out_valid, 0);
    check("compute_in_ready", in_ready, 0);
  endtask

  task automatic run_block(input arr4_t r, input arr4_t i, input arr4_t wr, input arr4_t wi,
                           input int maxgap, input int rdy_pct, input int stall_k);
    load_block(r, i, maxgap);
    pull(wr, wi, rdy_pct, stall_k, -1);
  endtask

  arr4_t sr, si, er, ei, orr, ori;

  initial begin
    out_ready = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_Xr_out", Xr_out, 0);
    check("rst_Xi_out", Xi_out, 0);
    check("rst_busy", busy, 0);
    RST = 1'b0;
    out_ready = 1'b0;

    // Impulse at x0
    sr = '{1, 0, 0, 0}; si = '{0, 0, 0, 0};
    dft4(sr, si, 1'b1, er, ei);
    run_block(sr, si, er, ei, 0, 100, -1);

    // Shifted impulse, expected values written out directly
    sr = '{0, 1, 0, 0}; si = '{0, 0, 0, 0};
    er = '{1, 0, -1, 0}; ei = '{0, 1, 0, -1};
    run_block(sr, si, er, ei, 0, 100, -1);

    // Extremes
    sr = '{-8, -8, -8, -8}; si = '{-8, -8, -8, -8};
    er = '{-32, 0, 0, 0}; ei = '{-32, 0, 0, 0};
    run_block(sr, si, er, ei, 0, 100, -1);
    sr = '{7, 7, 7, 7}; si = '{7, 7, 7, 7};
    er = '{28, 0, 0, 0}; ei = '{28, 0, 0, 0};
    run_block(sr, si, er, ei, 0, 100, -1);

    // Backpressure: three stall cycles while X1 is presented
    sr = '{3, -2, 5, -7}; si = '{-1, 4, -8, 6};
    dft4(sr, si, 1'b1, er, ei);
    run_block(sr, si, er, ei, 0, 100, 1);

    // Reset after two accepted samples
    push(5, 5, 0);
    @(negedge CLK);
    in_valid = 1'b0;
    check("busy_partial", busy, 1);
    check("in_ready_partial", in_ready, 1);
    push(-3, 2, 0);
    @(negedge CLK);
    in_valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("rst_load_busy", busy, 0);
    check("rst_load_in_ready", in_ready, 1);
    sr = '{1, 2, -1, 0}; si = '{0, -4, 3, 2};
    dft4(sr, si, 1'b1, er, ei);
    run_block(sr, si, er, ei, 1, 100, -1);

    // Reset while X2 is presented
    sr = '{-6, 1, 4, 2}; si = '{7, -5, 0, -3};
    dft4(sr, si, 1'b1, er, ei);
    load_block(sr, si, 0);
    out_ready = 1'b1;
    pull(er, ei, 100, -1, 2);
    RST = 1'b1;
    out_ready = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("rst_emit_out_valid", out_valid, 0);
    check("rst_emit_in_ready", in_ready, 1);
    check("rst_emit_out_idx", out_idx, 0);
    check("rst_emit_busy", busy, 0);
    sr = '{2, 2, -2, -2}; si = '{1, -1, 1, -1};
    dft4(sr, si, 1'b1, er, ei);
    run_block(sr, si, er, ei, 0, 100, -1);

    // Random full-range blocks with handshake gaps
    for (int b = 0; b < 200; b++) begin
      for (int n = 0; n < 4; n++) begin
        sr[n] = int'($urandom_range(0, 15)) - 8;
        si[n] = int'($urandom_range(0, 15)) - 8;
      end
      dft4(sr, si, 1'b1, er, ei);
      run_block(sr, si, er, ei, 2, 60, -1);
    end

    // Round trip: forward DFT-4 then this block gives 4x the original
    for (int b = 0; b < 1000; b++) begin
      for (int n = 0; n < 4; n++) begin
        orr[n] = int'($urandom_range(0, 3)) - 2;
        ori[n] = int'($urandom_range(0, 3)) - 2;
      end
      dft4(orr, ori, 1'b0, sr, si);
      for (int n = 0; n < 4; n++) begin
        er[n] = 4 * orr[n];
        ei[n] = 4 * ori[n];
      end
      run_block(sr, si, er, ei, 2, 70, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
